// File: rtl/regfile_writeback.sv
// Register file write-back queue: arbitrates ALU and memory results round-robin,
// buffers them in a small FIFO, drains one write per cycle and forwards the
// youngest pending value for two snooped read addresses.
module regfile_writeback #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 3,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              stall,
  output logic              w_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CNT_W-1:0]  pending_count,
  output logic              idle
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  src_e              rr_q, rr_d;

  logic              full, empty;
  logic              gnt_alu, gnt_mem;
  logic              accept, push, pop;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Arbitration, handshake and drain control; rr only matters when both sources are valid.
  always_comb begin
    gnt_alu  = alu_valid & (~mem_valid | (rr_q == SRC_ALU));
    gnt_mem  = mem_valid & (~alu_valid | (rr_q == SRC_MEM));
    alu_ready = gnt_alu & ~full;
    mem_ready = gnt_mem & ~full;
    accept   = alu_ready | mem_ready;
    acc_addr = gnt_alu ? alu_addr : mem_addr;
    acc_data = gnt_alu ? alu_data : mem_data;
    // Writes to r0 complete the handshake but are dropped here.
    push     = accept & (acc_addr != '0);
    pop      = ~empty & ~stall;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rr_d     = rr_q;
    if (accept) rr_d = (rr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end

  // Pointer, occupancy and round-robin state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= SRC_ALU;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  // FIFO storage; contents are only ever read below the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= acc_addr;
      data_mem_q[wr_ptr_q] <= acc_data;
    end
  end

  // Write port drives the head; zeroed whenever no write is issued.
  always_comb begin
    w_en       = pop;
    write_addr = pop ? addr_mem_q[rd_ptr_q] : '0;
    write_data = pop ? data_mem_q[rd_ptr_q] : '0;
  end

  // Forwarding: scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((read_addr1 != '0) && (addr_mem_q[idx] == read_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem_q[idx];
        end
        if ((read_addr2 != '0) && (addr_mem_q[idx] == read_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem_q[idx];
        end
      end
    end
  end

  assign pending_count = count_q;
  assign idle          = empty;

endmodule
